alu_nibble_sequencer: RTL and testbench
=======================================

// Module: alu_nibble_sequencer
// PURPOSE
//  Multi-nibble operation sequencer wrapped around the 4-bit ROM ALU.
//  Latches N-nibble operands, drives the ALU one nibble per clock (LS nibble first) and chains carry between nibbles.
//  Collects the result nibbles and merges NZVC flags into one word-wide result/flags pair, with a start/busy/done handshake.
//  Sits between the datapath registers and the ALU: it feeds the ALU's A/B/ALUop/Cin/enable/ALUbank inputs and consumes its result/flags.
// PARAMETERS
//  NIBBLES  4  word width in nibbles (>=2); data width W = 4*NIBBLES
// PORTS
//  clk          in   1    system clock, rising edge
//  reset_n      in   1    asynchronous, active-low reset
//  start        in   1    request; sampled only in IDLE
//  opA          in   W    first operand
//  opB          in   W    second operand
//  op           in   3    ALU operation code, held for all nibbles
//  bank         in   1    ALU operation bank, held for all nibbles
//  carry_in     in   1    carry into nibble 0
//  busy         out  1    high while nibbles are being sequenced
//  done         out  1    one-cycle completion pulse
//  result       out  W    word result, updated only at completion
//  flags        out  4    word NZVC {N,Z,V,C}, updated only at completion
//  alu_A        out  4    to ALU A
//  alu_B        out  4    to ALU B
//  alu_op       out  3    to ALU ALUop
//  alu_cin      out  1    to ALU Cin
//  alu_enable   out  1    to ALU enable (active low)
//  alu_bank     out  1    to ALU ALUbank
//  alu_result   in   4    from ALU result
//  alu_flags    in   4    from ALU flags, {N,Z,V,C} in bits [3:0]
// BEHAVIOUR
//  Reset (async, reset_n low): state IDLE; busy=0, done=0, result=0, flags=0.
//    ALU drive: alu_enable=1, alu_A/B/op/cin/bank=0. Working regs and nibble index cleared.
//  FSM is IDLE -> RUN -> IDLE.
//  IDLE, start=1:
//    - latch opA, opB, op, bank, carry_in into working regs; idx=0; go RUN.
//  RUN, cycle idx:
//    - alu_enable=0; alu_A/B = latched nibble idx; alu_op/bank = latched values.
//    - alu_cin = carry_in for idx 0, else the C captured from nibble idx-1.
//    - ALU is combinational; capture alu_result and alu_flags at the end of the same cycle.
//    - working Z accumulates: zacc = zacc & alu_flags[2], starting from 1.
//  End of nibble NIBBLES-1 (same edge as its capture):
//    - result <= working word with the last nibble inserted.
//    - flags  <= {alu_flags[3], zacc & alu_flags[2], alu_flags[1], alu_flags[0]}.
//    - done=1 for one cycle; go IDLE.
//  Latency: start sampled at edge E -> busy=1 and nibble 0 in cycle E+1 -> done=1 in cycle E+NIBBLES+1.
//    Throughput is one op per NIBBLES+1 cycles.
//  busy is registered: 1 in exactly the NIBBLES RUN cycles, 0 otherwise. alu_enable = ~busy.
//  done and busy are never high together. done is high while in IDLE, so start in the done cycle is accepted.
//  start while busy: ignored, no queueing. Operand inputs are don't-care after the start edge.
//  result/flags hold their previous values throughout RUN and change only on the done edge.
//  Reset mid-RUN: immediate IDLE; no done; result/flags cleared.
//  Nibble index is a counter of width clog2(NIBBLES); it never wraps past NIBBLES-1.
// CONFIGURATION
//  ALU_SEQ_ABORT_EN defined: adds input port `abort` (1 bit).
//    - abort=1 in a RUN cycle: next edge returns to IDLE; busy=0, alu_enable=1.
//    - no done pulse; result/flags keep their pre-start values.
//    - abort in IDLE is ignored; abort and start both high in IDLE -> start wins.
//  ALU_SEQ_ABORT_EN undefined: no `abort` port; RUN always completes all NIBBLES cycles.
// TESTING (NIBBLES=4, bench ALU model loaded from the ALU ROM image)
//  1. Reset mid-op: start an ADD, pull reset_n low in RUN cycle 2
//     -> busy=0, done never pulses, result=0, flags=0, alu_enable=1 immediately.
//  2. ADD 0x00FF+0x0001, carry_in=0
//     -> done at start+5; result=0x0100; flags N=0 Z=0 V=0 C=0; alu_cin sequence 0,1,1,0.
//  3. ADD 0xFFFF+0x0001, carry_in=0
//     -> result=0x0000, Z=1, C=1. Also 0x7FFF+0x0001 -> result=0x8000, N=1, V=1.
//  4. Back-to-back ops: start held high across the done cycle
//     -> second op begins the next cycle; start pulses during busy are ignored
//        (exactly one done per accepted start).
//  5. result/flags stability: change opA/opB every cycle during RUN
//     -> result equals the operands latched at start; result/flags are unchanged until the done edge.
//  6. (ALU_SEQ_ABORT_EN) abort in RUN cycle 3
//     -> IDLE next edge, no done, result/flags equal the previous op's values.

Source files
------------

// File: rtl/alu_nibble_sequencer.sv
// Word-wide operation sequencer around the 4-bit ALU: issues one nibble per clock, LS first, chaining carry.
// Optional `abort` input is enabled by defining ALU_SEQ_ABORT_EN.
module alu_nibble_sequencer #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   opA,
    input  logic [4*NIBBLES-1:0]   opB,
    input  logic [2:0]             op,
    input  logic                   bank,
    input  logic                   carry_in,
`ifdef ALU_SEQ_ABORT_EN
    input  logic                   abort,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic [3:0]             flags,
    output logic [3:0]             alu_A,
    output logic [3:0]             alu_B,
    output logic [2:0]             alu_op,
    output logic                   alu_cin,
    output logic                   alu_enable,
    output logic                   alu_bank,
    input  logic [3:0]             alu_result,
    input  logic [3:0]             alu_flags
);

    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned REM_W = W - 4;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [REM_W-1:0]   a_q, a_d;
    logic [REM_W-1:0]   b_q, b_d;
    logic [REM_W-1:0]   res_q, res_d;
    logic               zacc_q, zacc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [W-1:0]       result_q, result_d;
    logic [3:0]         flags_q, flags_d;
    logic [3:0]         alu_a_q, alu_a_d;
    logic [3:0]         alu_b_q, alu_b_d;
    logic [2:0]         alu_op_q, alu_op_d;
    logic               alu_cin_q, alu_cin_d;
    logic               alu_bank_q, alu_bank_d;
    logic               abort_c;
    logic [W-1:0]       res_ext_c;

`ifdef ALU_SEQ_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    // Collected nibbles so far with the nibble currently on the ALU inserted on top.
    assign res_ext_c = {alu_result, res_q};

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            zacc_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            alu_cin_q  <= 1'b0;
            alu_bank_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            zacc_q     <= zacc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            alu_cin_q  <= alu_cin_d;
            alu_bank_q <= alu_bank_d;
        end
    end

    // Next-state logic; ALU drive for the coming cycle is precomputed so it leaves from flops.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        zacc_d     = zacc_q;
        done_d     = 1'b0;
        result_d   = result_q;
        flags_d    = flags_q;
        alu_a_d    = 4'h0;
        alu_b_d    = 4'h0;
        alu_op_d   = 3'h0;
        alu_cin_d  = 1'b0;
        alu_bank_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    idx_d      = '0;
                    a_d        = opA[W-1:4];
                    b_d        = opB[W-1:4];
                    res_d      = '0;
                    zacc_d     = 1'b1;
                    alu_a_d    = opA[3:0];
                    alu_b_d    = opB[3:0];
                    alu_op_d   = op;
                    alu_bank_d = bank;
                    alu_cin_d  = carry_in;
                end
            end
            S_RUN: begin
                if (abort_c) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else if (idx_q == LAST_IDX) begin
                    state_d  = S_IDLE;
                    idx_d    = '0;
                    done_d   = 1'b1;
                    result_d = res_ext_c;
                    flags_d  = {alu_flags[3], zacc_q & alu_flags[2], alu_flags[1], alu_flags[0]};
                end else begin
                    idx_d      = IDX_W'(idx_q + 1'b1);
                    a_d        = a_q >> 4;
                    b_d        = b_q >> 4;
                    res_d      = res_ext_c[W-1:4];
                    zacc_d     = zacc_q & alu_flags[2];
                    alu_a_d    = a_q[3:0];
                    alu_b_d    = b_q[3:0];
                    alu_op_d   = alu_op_q;
                    alu_bank_d = alu_bank_q;
                    // Carry out of this nibble feeds the next one.
                    alu_cin_d  = alu_flags[0];
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase

        busy_d = (state_d == S_RUN);
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign flags      = flags_q;
    assign alu_A      = alu_a_q;
    assign alu_B      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign alu_cin    = alu_cin_q;
    assign alu_bank   = alu_bank_q;
    assign alu_enable = ~busy_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer (NIBBLES=4) with a nibble ALU model and a word-level reference model.
module tb_alu_nibble_sequencer;

    localparam int unsigned NIB = 4;
    localparam int unsigned W   = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [W-1:0]  opA, opB;
    logic [2:0]    op;
    logic          bank;
    logic          carry_in;
`ifdef ALU_SEQ_ABORT_EN
    logic          abort;
`endif
    logic          busy, done;
    logic [W-1:0]  result;
    logic [3:0]    flags;
    logic [3:0]    alu_A, alu_B;
    logic [2:0]    alu_op;
    logic          alu_cin, alu_enable, alu_bank;
    logic [3:0]    alu_result, alu_flags;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] last_res;
    logic [3:0]   last_flags;

    always #5 clk = ~clk;

    alu_nibble_sequencer #(.NIBBLES(NIB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .opA        (opA),
        .opB        (opB),
        .op         (op),
        .bank       (bank),
        .carry_in   (carry_in),
`ifdef ALU_SEQ_ABORT_EN
        .abort      (abort),
`endif
        .busy       (busy),
        .done       (done),
        .result     (result),
        .flags      (flags),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_op     (alu_op),
        .alu_cin    (alu_cin),
        .alu_enable (alu_enable),
        .alu_bank   (alu_bank),
        .alu_result (alu_result),
        .alu_flags  (alu_flags)
    );

    // Combinational 4-bit ALU model: bank 1 swaps the operands.
    logic [3:0] m_a, m_b, m_be;
    logic [4:0] m_s;
    logic       m_arith;
    always_comb begin
        m_a = alu_bank ? alu_B : alu_A;
        m_b = alu_bank ? alu_A : alu_B;
        m_be = (alu_op == 3'd1) ? ~m_b : m_b;
        m_arith = (alu_op == 3'd0) || (alu_op == 3'd1);
        case (alu_op)
            3'd0, 3'd1: m_s = {1'b0, m_a} + {1'b0, m_be} + {4'b0, alu_cin};
            3'd2:       m_s = {1'b0, m_a & m_b};
            3'd3:       m_s = {1'b0, m_a | m_b};
            3'd4:       m_s = {1'b0, m_a ^ m_b};
            3'd5:       m_s = {1'b0, m_a};
            3'd6:       m_s = {1'b0, ~m_a};
            default:    m_s = {1'b0, m_b};
        endcase
        alu_result = 4'h0;
        alu_flags  = 4'h0;
        if (!alu_enable) begin
            alu_result = m_s[3:0];
            alu_flags  = {m_s[3], m_s[3:0] == 4'h0,
                          m_arith && (m_a[3] == m_be[3]) && (m_s[3] != m_a[3]),
                          m_arith && m_s[4]};
        end
    end

    // Word-level reference: returns {flags, result}.
    function automatic logic [W+3:0] ref_op(input logic [2:0] o, input logic bk,
                                            input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic ci);
        logic [W-1:0] p, q, r;
        logic [W:0]   s;
        logic         ar, v, c;
        p = bk ? y : x;
        q = bk ? x : y;
        ar = (o == 3'd0) || (o == 3'd1);
        if (o == 3'd1) q = ~q;
        case (o)
            3'd0, 3'd1: s = {1'b0, p} + {1'b0, q} + (W+1)'(ci);
            3'd2:       s = {1'b0, p & q};
            3'd3:       s = {1'b0, p | q};
            3'd4:       s = {1'b0, p ^ q};
            3'd5:       s = {1'b0, p};
            3'd6:       s = {1'b0, ~p};
            default:    s = {1'b0, q};
        endcase
        r = s[W-1:0];
        v = ar && (p[W-1] == q[W-1]) && (r[W-1] != p[W-1]);
        c = ar && s[W];
        return {r[W-1], r == '0, v, c, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and wait for done; lat counts edges from the start edge to done.
    task automatic do_op(input logic [2:0] o, input logic bk, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic ci,
                         output int lat, output logic [3:0] cins);
        opA = x; opB = y; op = o; bank = bk; carry_in = ci; start = 1'b1;
        cins = 4'h0;
        tick();
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            if (busy && lat <= 4) cins[lat-1] = alu_cin;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_tests++; if (result !== 16'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
        n_tests++; if (flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags got %b want 0", flags); end
        n_tests++; if (alu_enable !== 1'b1 || alu_A !== 4'h0 || alu_cin !== 1'b0)
            begin n_fail++; $display("FAIL reset_alu_drive got en=%b A=%h cin=%b want 1/0/0", alu_enable, alu_A, alu_cin); end
        last_res = '0; last_flags = '0;
    endtask

    task automatic test_add_basic();
        int lat; logic [3:0] cins;
        do_op(3'd0, 1'b0, 16'h00FF, 16'h0001, 1'b0, lat, cins);
        n_tests++; if (lat != 5) begin n_fail++; $display("FAIL add_latency got %0d want 5", lat); end
        n_tests++; if (result !== 16'h0100) begin n_fail++; $display("FAIL add_result got %h want 0100", result); end
        n_tests++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL add_flags got %b want 0000", flags); end
        n_tests++; if (cins !== 4'b0110) begin n_fail++; $display("FAIL add_cin_seq got %b want 0110 (nibble3..0)", cins); end
        tick();
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle got %b want 0", done); end
        last_res = 16'h0100; last_flags = 4'b0000;
    endtask

    task automatic test_add_edges();
        int lat; logic [3:0] cins;
        do_op(3'd0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, lat, cins);
        n_tests++; if (result !== 16'h0000) begin n_fail++; $display("FAIL wrap_result got %h want 0000", result); end
        n_tests++; if (flags !== 4'b0101) begin n_fail++; $display("FAIL wrap_flags got %b want 0101", flags); end
        do_op(3'd0, 1'b0, 16'h7FFF, 16'h0001, 1'b0, lat, cins);
        n_tests++; if (result !== 16'h8000) begin n_fail++; $display("FAIL ovf_result got %h want 8000", result); end
        n_tests++; if (flags !== 4'b1010) begin n_fail++; $display("FAIL ovf_flags got %b want 1010", flags); end
        last_res = 16'h8000; last_flags = 4'b1010;
        tick();
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        opA = 16'h1234; opB = 16'h4321; op = 3'd0; bank = 1'b0; carry_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 reset_n = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b want 0", busy); end
        n_tests++; if (alu_enable !== 1'b1) begin n_fail++; $display("FAIL midreset_enable got %b want 1", alu_enable); end
        n_tests++; if (result !== 16'h0 || flags !== 4'h0)
            begin n_fail++; $display("FAIL midreset_result got %h/%b want 0000/0000", result, flags); end
        tick();
        reset_n = 1'b1;
        repeat (8) begin tick(); if (done) dones++; end
        n_tests++; if (dones != 0) begin n_fail++; $display("FAIL midreset_no_done got %0d want 0", dones); end
        last_res = '0; last_flags = '0;
    endtask

    task automatic test_random();
        int lat; logic [3:0] cins;
        logic [2:0] o; logic bk, ci; logic [W-1:0] x, y; logic [W+3:0] exp;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7)); bk = 1'($urandom); ci = 1'($urandom);
            x = 16'($urandom); y = 16'($urandom);
            if (i < 4) y = ~x;
            exp = ref_op(o, bk, x, y, ci);
            do_op(o, bk, x, y, ci, lat, cins);
            n_tests++; if (lat != 5) begin n_fail++; $display("FAIL rand_latency[%0d] got %0d want 5", i, lat); end
            n_tests++; if (result !== exp[W-1:0])
                begin n_fail++; $display("FAIL rand_result[%0d] op=%0d bank=%b got %h want %h", i, o, bk, result, exp[W-1:0]); end
            n_tests++; if (flags !== exp[W+3:W])
                begin n_fail++; $display("FAIL rand_flags[%0d] op=%0d bank=%b got %b want %b", i, o, bk, flags, exp[W+3:W]); end
            last_res = exp[W-1:0]; last_flags = exp[W+3:W];
        end
    endtask

    task automatic test_stability();
        int guard = 0; logic [W+3:0] exp;
        opA = 16'($urandom); opB = 16'($urandom); op = 3'd1; bank = 1'b0; carry_in = 1'b1;
        exp = ref_op(op, bank, opA, opB, carry_in);
        start = 1'b1;
        tick();
        start = 1'b0;
        while (busy && guard < 10) begin
            opA = 16'($urandom); opB = 16'($urandom);
            n_tests++; if (result !== last_res || flags !== last_flags)
                begin n_fail++; $display("FAIL hold_during_run got %h/%b want %h/%b", result, flags, last_res, last_flags); end
            tick();
            guard++;
        end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL stab_done got %b want 1", done); end
        n_tests++; if (result !== exp[W-1:0] || flags !== exp[W+3:W])
            begin n_fail++; $display("FAIL stab_result got %h/%b want %h/%b", result, flags, exp[W-1:0], exp[W+3:W]); end
        last_res = exp[W-1:0]; last_flags = exp[W+3:W];
        tick();
    endtask

    task automatic test_back_to_back();
        int dones = 0; logic [W+3:0] exp;
        opA = 16'h0ABC; opB = 16'h1F0F; op = 3'd0; bank = 1'b1; carry_in = 1'b1;
        exp = ref_op(op, bank, opA, opB, carry_in);
        start = 1'b1;
        for (int t = 1; t <= 25; t++) begin
            tick();
            if (done) begin
                dones++;
                n_tests++; if (result !== exp[W-1:0])
                    begin n_fail++; $display("FAIL b2b_result got %h want %h", result, exp[W-1:0]); end
            end
            if (busy && done) begin n_tests++; n_fail++; $display("FAIL busy_done_overlap got 1 want 0"); end
            if (t == 6) begin
                n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart busy got %b want 1", busy); end
            end
        end
        start = 1'b0;
        n_tests++; if (dones != 5) begin n_fail++; $display("FAIL b2b_done_count got %0d want 5", dones); end
        tick();
        dones = 0;
        start = 1'b1;
        tick();
        start = 1'b1; tick();
        start = 1'b0; tick();
        start = 1'b1; tick();
        start = 1'b0;
        for (int t = 0; t < 10; t++) begin if (done) dones++; tick(); end
        n_tests++; if (dones != 1) begin n_fail++; $display("FAIL ignore_start_busy got %0d dones want 1", dones); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_start_idle busy got %b want 0", busy); end
        last_res = exp[W-1:0]; last_flags = exp[W+3:W];
    endtask

`ifdef ALU_SEQ_ABORT_EN
    task automatic test_abort();
        int dones = 0; int lat; logic [3:0] cins; logic [W+3:0] exp;
        opA = 16'h5555; opB = 16'h3333; op = 3'd4; bank = 1'b0; carry_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_tests++; if (busy !== 1'b0 || alu_enable !== 1'b1 || done !== 1'b0)
            begin n_fail++; $display("FAIL abort_idle got busy=%b en=%b done=%b want 0/1/0", busy, alu_enable, done); end
        n_tests++; if (result !== last_res || flags !== last_flags)
            begin n_fail++; $display("FAIL abort_keep got %h/%b want %h/%b", result, flags, last_res, last_flags); end
        repeat (6) begin tick(); if (done) dones++; end
        n_tests++; if (dones != 0) begin n_fail++; $display("FAIL abort_no_done got %0d want 0", dones); end
        abort = 1'b1;
        exp = ref_op(3'd2, 1'b0, 16'hF0F0, 16'hFF00, 1'b0);
        do_op(3'd2, 1'b0, 16'hF0F0, 16'hFF00, 1'b0, lat, cins);
        n_tests++; if (lat != 20) begin n_fail++; $display("FAIL abort_start_wins got lat %0d want 20 (aborted)", lat); end
        abort = 1'b0;
        do_op(3'd2, 1'b0, 16'hF0F0, 16'hFF00, 1'b0, lat, cins);
        n_tests++; if (result !== exp[W-1:0]) begin n_fail++; $display("FAIL abort_recover got %h want %h", result, exp[W-1:0]); end
        tick();
    endtask
`endif

    initial begin
        start = 1'b0; opA = '0; opB = '0; op = '0; bank = 1'b0; carry_in = 1'b0;
`ifdef ALU_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        reset_n = 1'b0;
        test_reset();
        test_add_basic();
        test_add_edges();
        test_reset_mid();
        test_random();
        test_stability();
        test_back_to_back();
`ifdef ALU_SEQ_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
